// File: rtl/pe_pkg.sv
// Shared types and default geometry for the MAC processing element.
// The FSM walks IDLE -> MUL -> ACC -> DONE once per accepted request.
package pe_pkg;

    localparam int PE_SIZE       = 8;
    localparam int PE_L_RAM_SIZE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } pe_state_t;

endpackage : pe_pkg

// File: rtl/pe_ram.sv
// Local operand RAM: synchronous write, combinational read, contents untouched by reset.
// A read in the same cycle as a write to that address returns the old word.
module pe_ram
    import pe_pkg::*;
#(
    parameter int SIZE       = PE_SIZE,
    parameter int L_RAM_SIZE = PE_L_RAM_SIZE
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic [SIZE-1:0]       din,
    output logic [SIZE-1:0]       dout
);

    logic [SIZE-1:0] mem [2**L_RAM_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign dout = mem[addr];

endmodule : pe_ram

// File: rtl/my_pe_v1.sv
// Multiply-accumulate leaf PE: dout accumulates ain * ram[addr] per accepted request,
// with a one-cycle dvalid pulse two edges after acceptance.
module my_pe_v1
    import pe_pkg::*;
#(
    parameter int SIZE       = PE_SIZE,
    parameter int L_RAM_SIZE = PE_L_RAM_SIZE
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [SIZE-1:0]       ain,
    input  logic [SIZE-1:0]       din,
    input  logic [L_RAM_SIZE-1:0] addr,
    input  logic                  we,
    input  logic                  valid,
    output logic                  dvalid,
    output logic [SIZE-1:0]       dout
);

    pe_state_t state, state_nxt;

    logic [SIZE-1:0]   ram_rd;
    logic [SIZE-1:0]   a_p0;
    logic [SIZE-1:0]   b_p0;
    logic [2*SIZE-1:0] prod_p1;
    logic [SIZE-1:0]   psum_p2;
    logic              accept;

    // Accumulation is unsigned and wraps modulo 2**SIZE.
    function automatic logic [SIZE-1:0] wrap_acc(input logic [SIZE-1:0]   acc,
                                                 input logic [2*SIZE-1:0] p);
        return SIZE'({{SIZE{1'b0}}, acc} + p);
    endfunction

    pe_ram #(
        .SIZE       (SIZE),
        .L_RAM_SIZE (L_RAM_SIZE)
    ) u_ram (
        .clk  (aclk),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (ram_rd)
    );

    // A write in the same cycle takes priority over a MAC request.
    assign accept = (state == IDLE) && valid && !we;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     state_nxt = ACC;
            ACC:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: capture operands on accept
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            a_p0 <= '0;
            b_p0 <= '0;
        end else if (accept) begin
            a_p0 <= ain;
            b_p0 <= ram_rd;
        end
    end

    // Stage p1: full-width product
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prod_p1 <= '0;
        end else if (state == MUL) begin
            prod_p1 <= a_p0 * b_p0;
        end
    end

    // Stage p2: accumulate and flag completion
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            psum_p2 <= '0;
            dvalid  <= 1'b0;
        end else begin
            dvalid <= (state == ACC);
            if (state == ACC) begin
                psum_p2 <= wrap_acc(psum_p2, prod_p1);
            end
        end
    end

    assign dout = psum_p2;

endmodule : my_pe_v1

// File: tb/tb_my_pe_v1.sv
// Directed bench for my_pe_v1: load, accumulate, held valid, overflow, address wrap,
// reset mid-operation. Inputs change and outputs are sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_my_pe_v1;

    localparam int SIZE       = 8;
    localparam int L_RAM_SIZE = 3;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic [SIZE-1:0]       ain;
    logic [SIZE-1:0]       din;
    logic [L_RAM_SIZE-1:0] addr;
    logic                  we;
    logic                  valid;
    logic                  dvalid;
    logic [SIZE-1:0]       dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    my_pe_v1 #(
        .SIZE       (SIZE),
        .L_RAM_SIZE (L_RAM_SIZE)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .ain     (ain),
        .din     (din),
        .addr    (addr),
        .we      (we),
        .valid   (valid),
        .dvalid  (dvalid),
        .dout    (dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ram_write(input logic [L_RAM_SIZE-1:0] a, input logic [SIZE-1:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
    endtask

    // One request; checks dvalid timing across E0..E3 and dout when dvalid is high.
    task automatic mac(input string tag, input logic [SIZE-1:0] a,
                       input logic [L_RAM_SIZE-1:0] ad, input logic [SIZE-1:0] exp_dout);
        valid = 1'b1;
        ain   = a;
        addr  = ad;
        tick();
        valid = 1'b0;
        chk({tag, "_dv_e0"}, dvalid, 1'b0);
        tick();
        chk({tag, "_dv_e1"}, dvalid, 1'b0);
        tick();
        chk({tag, "_dv_e2"}, dvalid, 1'b1);
        chk({tag, "_dout"}, dout, exp_dout);
        tick();
        chk({tag, "_dv_e3"}, dvalid, 1'b0);
        chk({tag, "_hold"}, dout, exp_dout);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        int pulses;
        aresetn = 1'b0;
        ain     = '0;
        din     = '0;
        addr    = '0;
        we      = 1'b0;
        valid   = 1'b0;
        tick();
        do_reset();
        chk("rst_dvalid", dvalid, 1'b0);
        chk("rst_dout", dout, 8'h00);

        // Load ram[i] = i+1
        for (int i = 0; i < 8; i++) begin
            ram_write(L_RAM_SIZE'(i), SIZE'(i + 1));
        end

        mac("mac0", 8'd2, 3'd0, 8'd2);
        mac("mac1", 8'd3, 3'd1, 8'd8);
        mac("mac2", 8'd4, 3'd2, 8'd20);

        // Valid held two cycles: one operation, 20 + 1*4 = 24
        valid  = 1'b1;
        ain    = 8'd1;
        addr   = 3'd3;
        pulses = 0;
        tick();
        pulses += int'(dvalid);
        tick();
        valid  = 1'b0;
        pulses += int'(dvalid);
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(dvalid);
        end
        chk("held_pulses", pulses, 1);
        chk("held_dout", dout, 8'd24);

        // valid together with we is ignored (rewrites ram[5] with its own value)
        valid  = 1'b1;
        we     = 1'b1;
        addr   = 3'd5;
        din    = 8'd6;
        ain    = 8'd9;
        pulses = 0;
        tick();
        valid = 1'b0;
        we    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulses += int'(dvalid);
            tick();
        end
        chk("vwe_pulses", pulses, 0);
        chk("vwe_dout", dout, 8'd24);

        // Overflow from psum = 0
        do_reset();
        chk("ovf_rst_dout", dout, 8'h00);
        ram_write(3'd7, 8'hFF);
        mac("ovf0", 8'hFF, 3'd7, 8'h01);
        ram_write(3'd0, 8'h10);
        mac("ovf1", 8'h10, 3'd0, 8'h01);

        // Address wrap: second pass overwrites first
        for (int i = 0; i < 16; i++) begin
            ram_write(L_RAM_SIZE'(i), SIZE'(8'h20 + i));
        end
        mac("wrap0", 8'd1, 3'd0, 8'h29);
        mac("wrap7", 8'd1, 3'd7, 8'h58);

        // Reset mid-operation
        ram_write(3'd4, 8'd5);
        valid = 1'b1;
        ain   = 8'd3;
        addr  = 3'd4;
        tick();
        valid   = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("mid_rst_dout", dout, 8'h00);
        pulses = int'(dvalid);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(dvalid);
        end
        chk("mid_rst_pulses", pulses, 0);
        chk("mid_rst_dout2", dout, 8'h00);
        mac("post_rst", 8'd1, 3'd4, 8'd5);
        mac("ram_kept", 8'd1, 3'd0, 8'h2D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_my_pe_v1

// File: doc/my_pe_v1.md
Name: my_pe_v1

Overview:
- Single multiply-accumulate processing element with a small local operand RAM.
- Weights are loaded into the RAM via a write port. Each accepted `valid` request multiplies the input `ain` by `ram[addr]` and adds the product to a running partial sum.
- The partial sum is presented on `dout`, and completion is flagged by a one-cycle `dvalid` pulse.
- Sits as the leaf compute unit beneath a matrix/vector controller.

Parameters:
- SIZE, 8, data width of `ain`, `din`, RAM words, accumulator and `dout`.
- L_RAM_SIZE, 3, address width; the RAM holds 2**L_RAM_SIZE words.

Ports:
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  synchronous active-low reset.
- ain  in  SIZE  multiplicand for a MAC request.
- din  in  SIZE  RAM write data.
- addr  in  L_RAM_SIZE  RAM address, used for both writes and MAC reads.
- we  in  1  RAM write enable.
- valid  in  1  MAC request.
- dvalid  out  1  one-cycle completion pulse.
- dout  out  SIZE  accumulated partial sum (registered).

Behaviour:
- Reset (aresetn=0 at an edge):
  - state <= IDLE, dvalid <= 0, psum <= 0, operand/product registers <= 0.
  - RAM contents are NOT cleared.
- RAM write:
  - When we=1 at an edge, `ram[addr] <= din`. This happens in any FSM state.
  - `addr` wraps naturally modulo 2**L_RAM_SIZE.
- Request acceptance:
  - A request is accepted at an edge only when state=IDLE, valid=1 and we=0.
  - valid while not IDLE is ignored, so a multi-cycle valid level yields exactly one operation.
  - valid together with we=1 is ignored.
- FSM: IDLE -> MUL -> ACC -> DONE -> IDLE.
  - Edge E0 (accept): a_reg <= ain, b_reg <= ram[addr] (the pre-write value is read if a write coincides); IDLE->MUL.
  - E1: prod <= a_reg*b_reg, unsigned, 2*SIZE bits; MUL->ACC.
  - E2: psum <= (psum + prod) truncated to SIZE bits (unsigned modulo 2**SIZE); dvalid <= 1; ACC->DONE.
  - E3: dvalid <= 0; DONE->IDLE.
- Timing consequences:
  - The earliest next accept is E4.
  - Latency from accept edge to dvalid rising is 2 cycles; the dvalid pulse width is exactly 1 cycle.
- Output:
  - `dout` = psum register.
  - It updates in the same edge dvalid rises and holds between operations.
  - psum is cleared only by reset.
- Reset mid-operation: the operation is aborted, no dvalid pulse is produced, and psum=0.

Decomposition:
- Package pe_pkg: FSM state enum (IDLE, MUL, ACC, DONE) and default SIZE/L_RAM_SIZE constants.
- One natural sub-module: pe_ram (single-port synchronous-write, combinational-read RAM, 2**L_RAM_SIZE x SIZE).
- FSM and datapath live in the top level.

Test Plan:
- Load and single MAC:
  - Stimulus: reset, then write ram[i]=i+1 for i=0..7; then valid=1 with addr=0, ain=2.
  - Required: dvalid pulses one cycle, 2 cycles after the accept edge; dout=2.
- Accumulation:
  - Stimulus: continue with ain=3, addr=1 (ram=2), then ain=4, addr=2 (ram=3).
  - Required: dout=8, then 20; one dvalid per request.
- Held valid:
  - Stimulus: valid held high 2 cycles in IDLE.
  - Required: exactly one dvalid pulse; psum increments once.
- Overflow:
  - Stimulus: ram[7]=0xFF, ain=0xFF, starting psum=0.
  - Required: dout=0x01 (0xFE01 truncated).
  - Stimulus: a further ain=0x10 with ram[0]=0x10.
  - Required: dout=0x01 (0x01+0x100 wraps to 0x01).
- Address wrap / rewrite:
  - Stimulus: 16 consecutive writes with addr incrementing from 0 (addr wraps).
  - Required: ram holds the second-pass data; a MAC at addr=0 uses the value written at write #8.
- Reset mid-op:
  - Stimulus: aresetn=0 in the cycle after accept.
  - Required: dvalid stays 0, dout=0; a following request with ain=1, ram=5 gives dout=5, and RAM still holds the pre-reset contents.
